// File: rtl/complex_wb_arbiter.sv
// Writeback arbiter: buffers fixed-latency multiplier results in a small FIFO and shares one
// writeback port with the divider. Define COMPLEX_WB_AGING_EN to enable divider starvation aging.
module complex_wb_arbiter #(
    parameter int DATA_WIDTH   = 32,
    parameter int PTR_WIDTH    = 6,
    parameter int PREG_WIDTH   = 7,
    parameter int FIFO_DEPTH   = 4,
    parameter int STARVE_LIMIT = 3
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          stall,
    input  logic                          mulValid,
    input  logic [PTR_WIDTH-1:0]          mulPtr,
    input  logic [PREG_WIDTH-1:0]         mulDstReg,
    input  logic                          mulWriteReg,
    input  logic [DATA_WIDTH-1:0]         mulData,
    output logic                          mulStall,
    input  logic                          divValid,
    input  logic [PTR_WIDTH-1:0]          divPtr,
    input  logic [PREG_WIDTH-1:0]         divDstReg,
    input  logic                          divWriteReg,
    input  logic [DATA_WIDTH-1:0]         divData,
    output logic                          divReady,
    input  logic                          flushValid,
    input  logic                          flushAll,
    input  logic [PTR_WIDTH-1:0]          flushHeadPtr,
    input  logic [PTR_WIDTH-1:0]          flushTailPtr,
    output logic                          wbValid,
    output logic [PTR_WIDTH-1:0]          wbPtr,
    output logic [PREG_WIDTH-1:0]         wbDstReg,
    output logic                          wbRegWE,
    output logic [DATA_WIDTH-1:0]         wbData,
    output logic [$clog2(FIFO_DEPTH):0]   count,
    output logic                          overflow
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;

    if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 || STARVE_LIMIT < 1) begin : g_bad_param
        $error("complex_wb_arbiter: illegal FIFO_DEPTH or STARVE_LIMIT");
    end

    // Range [head,tail) wraps when head > tail; head == tail is empty unless flushAll.
    function automatic logic flush_hit(input logic [PTR_WIDTH-1:0] p, input logic fv, input logic fa,
                                       input logic [PTR_WIDTH-1:0] h, input logic [PTR_WIDTH-1:0] t);
        logic in_r;
        if (h < t)      in_r = (p >= h) && (p < t);
        else if (h > t) in_r = (p >= h) || (p < t);
        else            in_r = 1'b0;
        return fv && (fa || in_r);
    endfunction

    logic [FIFO_DEPTH-1:0] fvalid_q;
    logic [PTR_WIDTH-1:0]  fptr_q  [FIFO_DEPTH];
    logic [PREG_WIDTH-1:0] fdst_q  [FIFO_DEPTH];
    logic                  fwe_q   [FIFO_DEPTH];
    logic [DATA_WIDTH-1:0] fdata_q [FIFO_DEPTH];
    logic [AW-1:0]         rd_q, wr_q;
    logic [CW-1:0]         count_q, count_d;
    logic                  ovf_q;
    logic                  wb_valid_q, wb_we_q;
    logic [PTR_WIDTH-1:0]  wb_ptr_q;
    logic [PREG_WIDTH-1:0] wb_dst_q;
    logic [DATA_WIDTH-1:0] wb_data_q;

    logic head_live, div_hit, starve, div_sel, fifo_sel, pop, push, push_ok, div_acc;

`ifdef COMPLEX_WB_AGING_EN
    localparam int WW = $clog2(STARVE_LIMIT + 1);
    logic [WW-1:0] wait_q;
    assign starve = (wait_q >= WW'(STARVE_LIMIT));
`else
    assign starve = 1'b0;
`endif

    always_comb begin
        head_live = (count_q != '0) && fvalid_q[rd_q]
                    && !flush_hit(fptr_q[rd_q], flushValid, flushAll, flushHeadPtr, flushTailPtr);
        div_hit   = divValid && flush_hit(divPtr, flushValid, flushAll, flushHeadPtr, flushTailPtr);
        div_sel   = !stall && divValid && !div_hit && (!head_live || starve);
        fifo_sel  = !stall && head_live && !div_sel;
        // An invalidated head drains silently even when the divider wins the port.
        pop       = !stall && (count_q != '0) && (fifo_sel || !head_live);
        push      = !stall && mulValid
                    && !flush_hit(mulPtr, flushValid, flushAll, flushHeadPtr, flushTailPtr);
        push_ok   = push && ((count_q != CW'(FIFO_DEPTH)) || pop);
        div_acc   = !stall && divValid && (div_sel || div_hit);
        count_d   = count_q;
        if (push_ok && !pop)      count_d = count_q + CW'(1);
        else if (!push_ok && pop) count_d = count_q - CW'(1);
    end

    assign divReady = !rst && div_acc;
    assign mulStall = !rst && (count_q >= CW'(FIFO_DEPTH - 1));
    assign wbValid  = wb_valid_q
                      && !flush_hit(wb_ptr_q, flushValid, flushAll, flushHeadPtr, flushTailPtr);
    assign wbRegWE  = wbValid && wb_we_q;
    assign wbPtr    = wb_ptr_q;
    assign wbDstReg = wb_dst_q;
    assign wbData   = wb_data_q;
    assign count    = count_q;
    assign overflow = ovf_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fvalid_q   <= '0;
            rd_q       <= '0;
            wr_q       <= '0;
            count_q    <= '0;
            ovf_q      <= 1'b0;
            wb_valid_q <= 1'b0;
            wb_we_q    <= 1'b0;
            wb_ptr_q   <= '0;
            wb_dst_q   <= '0;
            wb_data_q  <= '0;
        end else begin
            // Flush invalidation keeps working while the back end is stalled.
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                if (flush_hit(fptr_q[i], flushValid, flushAll, flushHeadPtr, flushTailPtr))
                    fvalid_q[i] <= 1'b0;
            end
            if (!stall) begin
                if (push_ok) begin
                    fvalid_q[wr_q] <= 1'b1;
                    wr_q           <= wr_q + AW'(1);
                end
                if (pop) rd_q <= rd_q + AW'(1);
                count_q <= count_d;
                if (push && !push_ok) ovf_q <= 1'b1;
                wb_valid_q <= fifo_sel || div_sel;
                if (fifo_sel) begin
                    wb_ptr_q  <= fptr_q[rd_q];
                    wb_dst_q  <= fdst_q[rd_q];
                    wb_we_q   <= fwe_q[rd_q];
                    wb_data_q <= fdata_q[rd_q];
                end else if (div_sel) begin
                    wb_ptr_q  <= divPtr;
                    wb_dst_q  <= divDstReg;
                    wb_we_q   <= divWriteReg;
                    wb_data_q <= divData;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) begin
            fptr_q[wr_q]  <= mulPtr;
            fdst_q[wr_q]  <= mulDstReg;
            fwe_q[wr_q]   <= mulWriteReg;
            fdata_q[wr_q] <= mulData;
        end
    end

`ifdef COMPLEX_WB_AGING_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wait_q <= '0;
        end else if (!stall) begin
            if (divValid && !div_acc && !starve) wait_q <= wait_q + WW'(1);
            else if (!divValid || div_acc)       wait_q <= '0;
        end
    end
`endif
endmodule

// File: tb/tb_complex_wb_arbiter.sv
// Randomized and directed bench for complex_wb_arbiter against a queue-based reference model.
module tb_complex_wb_arbiter;
    localparam int DW = 32, PW = 6, RW = 7, DEPTH = 4, LIMIT = 3, CW = 3;

    logic clk = 1'b0;
    logic rst, stall;
    logic mulValid, mulWriteReg, divValid, divWriteReg, flushValid, flushAll;
    logic [PW-1:0] mulPtr, divPtr, flushHeadPtr, flushTailPtr;
    logic [RW-1:0] mulDstReg, divDstReg;
    logic [DW-1:0] mulData, divData;
    logic mulStall, divReady, wbValid, wbRegWE, overflow;
    logic [PW-1:0] wbPtr;
    logic [RW-1:0] wbDstReg;
    logic [DW-1:0] wbData;
    logic [CW-1:0] count;

    always #5 clk = ~clk;

    complex_wb_arbiter #(.DATA_WIDTH(DW), .PTR_WIDTH(PW), .PREG_WIDTH(RW),
                         .FIFO_DEPTH(DEPTH), .STARVE_LIMIT(LIMIT)) dut (
        .clk(clk), .rst(rst), .stall(stall),
        .mulValid(mulValid), .mulPtr(mulPtr), .mulDstReg(mulDstReg),
        .mulWriteReg(mulWriteReg), .mulData(mulData), .mulStall(mulStall),
        .divValid(divValid), .divPtr(divPtr), .divDstReg(divDstReg),
        .divWriteReg(divWriteReg), .divData(divData), .divReady(divReady),
        .flushValid(flushValid), .flushAll(flushAll),
        .flushHeadPtr(flushHeadPtr), .flushTailPtr(flushTailPtr),
        .wbValid(wbValid), .wbPtr(wbPtr), .wbDstReg(wbDstReg), .wbRegWE(wbRegWE),
        .wbData(wbData), .count(count), .overflow(overflow)
    );

    typedef struct {
        logic          v;
        logic [PW-1:0] ptr;
        logic [RW-1:0] dst;
        logic          we;
        logic [DW-1:0] data;
    } ent_t;

    ent_t mq[$];
    ent_t m_wb;
    int   m_wait;
    logic m_ovf;
    logic m_last_acc;
    int   n_vec = 0;
    int   n_err = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Distance from head modulo 64 must fall short of the range length.
    function automatic bit m_hit(input logic [PW-1:0] p);
        int span, off;
        if (!flushValid) return 1'b0;
        if (flushAll) return 1'b1;
        span = (int'(flushTailPtr) - int'(flushHeadPtr) + 64) % 64;
        off  = (int'(p) - int'(flushHeadPtr) + 64) % 64;
        return off < span;
    endfunction

    function automatic bit m_head_live();
        if (mq.size() == 0) return 1'b0;
        return mq[0].v && !m_hit(mq[0].ptr);
    endfunction

    function automatic bit m_starved();
`ifdef COMPLEX_WB_AGING_EN
        return m_wait >= LIMIT;
`else
        return 1'b0;
`endif
    endfunction

    function automatic bit m_div_sel();
        return !stall && divValid && !m_hit(divPtr) && (!m_head_live() || m_starved());
    endfunction

    function automatic bit m_ready();
        return !stall && divValid && (m_div_sel() || m_hit(divPtr));
    endfunction

    task automatic check_outputs();
        bit wv;
        wv = m_wb.v && !m_hit(m_wb.ptr);
        chk("divReady", divReady, m_ready());
        chk("mulStall", mulStall, mq.size() >= DEPTH - 1);
        chk("count", count, mq.size());
        chk("overflow", overflow, m_ovf);
        chk("wbValid", wbValid, wv);
        chk("wbRegWE", wbRegWE, wv && m_wb.we);
        chk("wbPtr", wbPtr, m_wb.ptr);
        chk("wbDstReg", wbDstReg, m_wb.dst);
        chk("wbData", wbData, m_wb.data);
    endtask

    task automatic model_edge();
        bit hl, ds, fs, rdy;
        hl  = m_head_live();
        ds  = m_div_sel();
        rdy = m_ready();
        if (!stall) begin
            fs = hl && !ds;
            if (fs) begin
                m_wb = mq[0];
                m_wb.v = 1'b1;
            end else if (ds) begin
                m_wb = '{v: 1'b1, ptr: divPtr, dst: divDstReg, we: divWriteReg, data: divData};
            end else begin
                m_wb.v = 1'b0;
            end
            if (mq.size() > 0 && (!hl || fs)) void'(mq.pop_front());
            if (divValid && !rdy) m_wait++;
            else m_wait = 0;
        end
        foreach (mq[i]) if (m_hit(mq[i].ptr)) mq[i].v = 1'b0;
        if (!stall && mulValid && !m_hit(mulPtr)) begin
            if (mq.size() == DEPTH) m_ovf = 1'b1;
            else mq.push_back('{v: 1'b1, ptr: mulPtr, dst: mulDstReg, we: mulWriteReg, data: mulData});
        end
        m_last_acc = rdy;
    endtask

    task automatic cycle();
        @(negedge clk);
        check_outputs();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic idle_inputs();
        stall = 0; mulValid = 0; mulWriteReg = 0; mulPtr = '0; mulDstReg = '0; mulData = '0;
        divValid = 0; divWriteReg = 0; divPtr = '0; divDstReg = '0; divData = '0;
        flushValid = 0; flushAll = 0; flushHeadPtr = '0; flushTailPtr = '0;
    endtask

    task automatic set_mul(input logic [PW-1:0] p, input logic [DW-1:0] d, input logic [RW-1:0] r);
        mulValid = 1; mulPtr = p; mulData = d; mulDstReg = r; mulWriteReg = 1;
    endtask

    task automatic do_reset();
        rst = 1;
        #1;
        chk("rst_count", count, 0);
        chk("rst_wbValid", wbValid, 0);
        chk("rst_divReady", divReady, 0);
        chk("rst_mulStall", mulStall, 0);
        chk("rst_overflow", overflow, 0);
        mq.delete();
        m_wb = '{v: 1'b0, ptr: '0, dst: '0, we: 1'b0, data: '0};
        m_wait = 0; m_ovf = 1'b0; m_last_acc = 1'b0;
        @(posedge clk);
        #1;
        chk("rst_wbPtr", wbPtr, 0);
        chk("rst_wbData", wbData, 0);
        rst = 0;
        idle_inputs();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int grant_k, exp_k;
        idle_inputs();
        rst = 0;
        #2;
        divValid = 1; divPtr = 6'd9;
        do_reset();

        // single multiplier result appears two cycles after mulValid
        set_mul(6'd5, 32'h1234, 7'd9);
        cycle();
        idle_inputs();
        cycle();
        chk("t1_wbValid", wbValid, 1);
        chk("t1_wbPtr", wbPtr, 5);
        chk("t1_wbData", wbData, 32'h1234);
        chk("t1_wbRegWE", wbRegWE, 1);
        cycle();
        chk("t1_wbValid_after", wbValid, 0);

        // buffered ptr 3 invalidated by flush [2,6); ptrs 1 and 7 survive
        set_mul(6'd1, 32'h11, 7'd1);
        cycle();
        set_mul(6'd3, 32'h33, 7'd3);
        cycle();
        chk("t2_wb1", wbPtr, 1);
        set_mul(6'd7, 32'h77, 7'd7);
        flushValid = 1; flushHeadPtr = 6'd2; flushTailPtr = 6'd6;
        cycle();
        idle_inputs();
        chk("t2_silent_pop", wbValid, 0);
        cycle();
        chk("t2_wb7_valid", wbValid, 1);
        chk("t2_wb7_ptr", wbPtr, 7);
        cycle();

        // wrapped flush [60,2): divPtr 63 sunk, divPtr 10 written back
        flushValid = 1; flushHeadPtr = 6'd60; flushTailPtr = 6'd2;
        divValid = 1; divPtr = 6'd63; divData = 32'hDEAD; divDstReg = 7'd4; divWriteReg = 1;
        #1;
        chk("t3_sink_ready", divReady, 1);
        cycle();
        chk("t3_sink_nowb", wbValid, 0);
        divPtr = 6'd10;
        #1;
        chk("t3_div10_ready", divReady, 1);
        cycle();
        idle_inputs();
        chk("t3_div10_wb", wbValid, 1);
        chk("t3_div10_ptr", wbPtr, 10);
        cycle();

        // continuous multiplier stream against a held divider result
        set_mul(6'd40, $urandom, 7'd2);
        cycle();
        divValid = 1; divPtr = 6'd20; divData = 32'hBEEF; divWriteReg = 1; divDstReg = 7'd5;
        grant_k = -1;
        for (int k = 0; k < 8; k++) begin
            set_mul(6'(41 + k), $urandom, 7'(k));
            #1;
            if (divReady && grant_k < 0) grant_k = k;
            cycle();
            if (m_last_acc) divValid = 0;
        end
`ifdef COMPLEX_WB_AGING_EN
        exp_k = LIMIT;
`else
        exp_k = -1;
`endif
        chk("t4_grant_cycle", 64'(grant_k), 64'(exp_k));
        mulValid = 0;
        for (int k = 0; k < 6; k++) begin
            cycle();
            if (m_last_acc) divValid = 0;
        end
        chk("t4_drained", count, 0);

        // randomized traffic with occasional mid-run reset
        for (int n = 0; n < 600; n++) begin
            if (n == 200 || n == 420) begin
                do_reset();
                continue;
            end
            if (m_last_acc) divValid = 0;
            stall = ($urandom_range(0, 99) < 15);
            mulValid = ($urandom_range(0, 99) < 60);
            mulPtr = 6'($urandom_range(0, 63));
            mulDstReg = 7'($urandom);
            mulWriteReg = 1'($urandom);
            mulData = $urandom;
            if (!divValid && $urandom_range(0, 99) < 35) begin
                divValid = 1;
                divPtr = 6'($urandom_range(0, 63));
                divDstReg = 7'($urandom);
                divWriteReg = 1'($urandom);
                divData = $urandom;
            end
            flushValid = ($urandom_range(0, 99) < 20);
            flushAll = ($urandom_range(0, 99) < 10);
            flushHeadPtr = 6'($urandom_range(0, 63));
            flushTailPtr = ($urandom_range(0, 9) == 0) ? flushHeadPtr : 6'($urandom_range(0, 63));
            cycle();
        end
        idle_inputs();
        cycle();
        chk("final_overflow", overflow, m_ovf);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
